piso: RTL and testbench
=======================

# piso

Parallel-in, serial-out converter with ready/valid handshakes on both sides. It is the transmit-side counterpart of the board's `sipo`: it accepts one `depth_p`-element word and emits it one `width_p`-bit element per beat. It sits between a word producer (register file, systolic array result, test pattern) and a narrow serial sink (LED/pin driver, downstream `sipo`). Back-to-back words stream with no idle cycles.

## Interface
- `width_p`, default 1: bits per serial element (beat).
- `depth_p`, default 8: elements per parallel word; legal range is 1 or more.
- `msb_first_p`, default 0: 0 means beat 0 carries `data_i[width_p-1:0]`; 1 means beat 0 carries the top slice `data_i[width_p*depth_p-1 -: width_p]`.

Ports:
- `clk_i`, in, 1: single clock. All logic is on the rising edge.
- `reset_n_i`, in, 1: asynchronous, active-low reset. Assertion takes effect immediately. Release is synchronous to `clk_i`, and the source guarantees this.
- `valid_i`, in, 1: parallel word on `data_i` is valid.
- `ready_o`, out, 1: block can accept a word this cycle.
- `data_i`, in, `width_p*depth_p`: parallel word. It is sampled only on the accept cycle.
- `valid_o`, out, 1: `data_o` holds a valid beat.
- `ready_i`, in, 1: sink consumes the beat this cycle.
- `data_o`, out, `width_p`: current serial element.
- `last_o`, out, 1: the current beat is the final element of its word.

## Operation
- Accept event: `valid_i & ready_o`. Beat-transfer event: `valid_o & ready_i`.
- Storage: one `width_p*depth_p` shift register, a beat counter of width `max(1,$clog2(depth_p))`, and a state register.
- States:
  - IDLE: `valid_o=0` and `ready_o=1`. On an accept, load the shift register, clear the counter and go to SEND.
  - SEND: `valid_o=1`. `data_o` is the head slice of the shift register. On a transfer, shift by `width_p` toward the head and increment the counter.
- `last_o = (state==SEND) & (count==depth_p-1)`.
- Leaving SEND:
  - If a transfer occurs with `last_o=1` and no accept, go to IDLE.
  - If a transfer occurs with `last_o=1` and an accept in the same cycle, load the new word, clear the counter and stay in SEND. There is no bubble.
- `ready_o = (state==IDLE) | (last_o & ready_i)`. This is a combinational path from `ready_i` to `ready_o`, and it is permitted.
- Words are never dropped, duplicated or reordered.
- While `valid_o=1` and `ready_i=0`:
  - `data_o` and `last_o` hold stable.
  - `data_i` changes are ignored.
- `valid_i` may drop without an accept.
- `depth_p==1`: every beat has `last_o=1`, and the counter stays at 0.
- The slice order within a word is fixed by `msb_first_p`. The shift direction is chosen to match.

## Timing
- Reset (while `reset_n_i=0`):
  - state is IDLE, count is 0, and the shift register is 0.
  - `valid_o=0`, `data_o=0`, `last_o=0`, `ready_o=0`. `ready_o` is gated low by reset.
- First cycle after release: `ready_o=1`.
- Latency: for an accept at edge N, beat 0 appears on `data_o` with `valid_o=1` after edge N.
- Throughput:
  - One beat per cycle while `ready_i=1`.
  - A word takes `depth_p` transfer cycles.
  - Continuous streaming gives `depth_p` cycles per word.
- Reset asserted mid-word: the partial word is discarded, and outputs go to their reset values asynchronously.
- `data_o`, `valid_o` and `last_o` are registered or decoded from registered state only. They have no combinational path from `ready_i` or `valid_i`.

## Structure
- Shared package `serial_pkg` holds:
  - `typedef enum logic [0:0] {IDLE, SEND} piso_state_e`.
  - A `clog2`-floor helper constant function, so that `sipo` can reuse it.
- Sub-module `beat_counter` (parameters `max_p`, `width_p`): synchronous clear, increment enable, and a `wrap_o` flag at `max_p-1`. It uses the same async active-low reset.
- The datapath shift register and the state machine are inline in `piso`.

## Test plan
- Reset value check:
  - Hold `reset_n_i=0` for 3 cycles, then release.
  - During reset: `valid_o=0`, `ready_o=0`, `data_o=0`, `last_o=0`.
  - One cycle after release: `ready_o=1`.
- Order, LSB first (`width_p=1`, `depth_p=8`, `msb_first_p=0`, `ready_i=1`):
  - Accept `8'hA5`. `data_o` reads 1,0,1,0,0,1,0,1 on consecutive cycles.
  - `last_o` is high only on the 8th beat, and `valid_o` drops the next cycle.
- Order, MSB first (`msb_first_p=1`):
  - Accept `8'hA5`. `data_o` reads 1,0,1,0,0,1,0,1.
  - Then accept `8'h0F`. `data_o` reads 0,0,0,0,1,1,1,1.
- Streaming:
  - Hold `valid_i=1` with `8'hFF`, then `8'h00`. The 2nd word is accepted on the `last_o` beat.
  - Result: 16 consecutive valid beats with no gap, and `last_o` on beats 8 and 16.
- Backpressure (`width_p=4`, `depth_p=2`):
  - Accept `8'h3C`. Hold `ready_i=0` for 5 cycles, then set it to 1.
  - `data_o=4'hC` is held stable for all 6 cycles, followed by `4'h3` with `last_o=1`.
- Mid-word reset:
  - After 3 of 8 beats, pulse `reset_n_i=0` asynchronously, mid-cycle.
  - Outputs clear immediately. After release, a new word `8'h81` serializes from beat 0 correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the board's serializer/deserializer pair.
//
// Contents:
//   piso_state_e : two-state control for the parallel-in, serial-out converter.
//   clog2_floor  : counter-width helper. It returns ceil(log2(value)) but never
//                  less than 1, so a one-element word still gets a legal
//                  1-bit counter. sipo sizes its counter with the same function.
package serial_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } piso_state_e;

  function automatic int clog2_floor(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat counter that counts 0 .. max_p-1 and then wraps back to 0.
//
// Ports:
//   clk_i     : clock, rising edge
//   reset_n_i : asynchronous active-low reset, clears the count to 0
//   clear_i   : synchronous clear. It takes priority over incr_i.
//   incr_i    : advance by one. At max_p-1 the count returns to 0.
//   wrap_o    : high while the count equals max_p-1. It is always high when
//               max_p is 1.
module beat_counter
  import serial_pkg::*;
#(
  parameter int max_p   = 8,
  parameter int width_p = clog2_floor(max_p)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic incr_i,
  output logic wrap_o
);

  localparam logic [width_p-1:0] last_count = width_p'(max_p - 1);

  logic [width_p-1:0] count_q;

  assign wrap_o = (count_q == last_count);

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples its pre-edge value, whatever order the processes evaluate in.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (incr_i) begin
      count_q <= wrap_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/piso.sv
// Parallel-in, serial-out converter with ready/valid on both sides.
//
// The block accepts one depth_p-element word and emits it as width_p-bit beats.
// A new word can be accepted on the final beat of the current word, so
// back-to-back words stream without idle cycles.
//
// Parameters:
//   width_p     : bits per beat
//   depth_p     : beats per word (1 or more)
//   msb_first_p : 0 = beat 0 is data_i[width_p-1:0]; 1 = beat 0 is the top slice
//
// Ports:
//   clk_i     : clock, rising edge
//   reset_n_i : asynchronous active-low reset. While it is low, ready_o is also
//               held low.
//   valid_i   : input word on data_i is valid
//   ready_o   : can accept a word this cycle. This is a combinational function
//               of ready_i while the last beat is on the output.
//   data_i    : parallel input word, sampled only on the accept cycle
//   valid_o   : data_o holds a valid beat
//   ready_i   : sink takes the beat this cycle
//   data_o    : current beat
//   last_o    : current beat is the final element of its word
module piso
  import serial_pkg::*;
#(
  parameter int width_p     = 1,
  parameter int depth_p     = 8,
  parameter bit msb_first_p = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [width_p*depth_p-1:0] data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o
);

  localparam int word_w = width_p * depth_p;

  piso_state_e       state_q;
  piso_state_e       state_d;
  logic [word_w-1:0] shift_q;
  logic              wrap;
  logic              accept;
  logic              xfer;

  // valid_o, last_o and data_o come only from registered state. ready_o is
  // the one output that looks at ready_i.
  assign valid_o = (state_q == SEND);
  assign last_o  = valid_o & wrap;
  assign ready_o = reset_n_i & (~valid_o | (last_o & ready_i));
  assign accept  = valid_i & ready_o;
  assign xfer    = valid_o & ready_i;

  // The head slice is the end of the register that the shift moves toward.
  if (msb_first_p) begin : g_head_msb
    assign data_o = shift_q[word_w-1 -: width_p];
  end else begin : g_head_lsb
    assign data_o = shift_q[width_p-1:0];
  end

  beat_counter #(
    .max_p   (depth_p),
    .width_p (clog2_floor(depth_p))
  ) u_beat_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (accept),
    .incr_i    (xfer),
    .wrap_o    (wrap)
  );

  // NOTE: the shift register is reset on purpose. data_o is decoded straight
  // from it, and data_o has to read 0 during reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shift_q <= '0;
    end else if (accept) begin
      shift_q <= data_i;
    end else if (xfer) begin
      shift_q <= msb_first_p ? (shift_q << width_p) : (shift_q >> width_p);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case statement. Every path then
  // assigns it, and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
        end
      end
      SEND: begin
        // An accept on the last beat reloads the register and keeps sending.
        if (xfer && last_o && !accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso. It uses three instances:
//   u_lsb : width 1, depth 8, LSB first (order, streaming, mid-word reset)
//   u_msb : width 1, depth 8, MSB first (order)
//   u_bp  : width 4, depth 2, LSB first (backpressure)
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge, except for the asynchronous-reset check.
module tb_piso;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic       a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_data_o, a_last_o;
  logic [7:0] a_data_i;
  logic       b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_data_o, b_last_o;
  logic [7:0] b_data_i;
  logic       c_valid_i, c_ready_o, c_valid_o, c_ready_i, c_last_o;
  logic [7:0] c_data_i;
  logic [3:0] c_data_o;

  int vectors     = 0;
  int miscompares = 0;

  piso #(.width_p(1), .depth_p(8), .msb_first_p(1'b0)) u_lsb (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_i(a_data_i), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .data_o(a_data_o), .last_o(a_last_o)
  );

  piso #(.width_p(1), .depth_p(8), .msb_first_p(1'b1)) u_msb (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_i(b_data_i), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .data_o(b_data_o), .last_o(b_last_o)
  );

  piso #(.width_p(4), .depth_p(2), .msb_first_p(1'b0)) u_bp (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(c_valid_i), .ready_o(c_ready_o),
    .data_i(c_data_i), .valid_o(c_valid_o), .ready_i(c_ready_i),
    .data_o(c_data_o), .last_o(c_last_o)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {7'b0, obs}, {7'b0, exp});
  endtask

  logic [7:0] pat;
  logic [7:0] msb_words [2];

  initial begin
    msb_words[0] = 8'hA5;
    msb_words[1] = 8'h0F;
    reset_n   = 1'b0;
    a_valid_i = 1'b0; a_data_i = 8'h00; a_ready_i = 1'b1;
    b_valid_i = 1'b0; b_data_i = 8'h00; b_ready_i = 1'b1;
    c_valid_i = 1'b0; c_data_i = 8'h00; c_ready_i = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst a_valid_o", a_valid_o, 1'b0);
    check1("rst a_ready_o", a_ready_o, 1'b0);
    check1("rst a_data_o",  a_data_o,  1'b0);
    check1("rst a_last_o",  a_last_o,  1'b0);
    check1("rst b_ready_o", b_ready_o, 1'b0);
    check ("rst c_data_o",  {4'h0, c_data_o}, 8'h00);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check1("post-rst a_ready_o", a_ready_o, 1'b1);
    check1("post-rst a_valid_o", a_valid_o, 1'b0);
    check1("post-rst c_ready_o", c_ready_o, 1'b1);

    // LSB-first order
    pat = 8'hA5;
    @(posedge clk); #1 a_valid_i = 1'b1; a_data_i = pat;
    @(posedge clk); #1 a_valid_i = 1'b0; a_data_i = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check1($sformatf("lsb data beat %0d", i),  a_data_o,  pat[i]);
      check1($sformatf("lsb valid beat %0d", i), a_valid_o, 1'b1);
      check1($sformatf("lsb last beat %0d", i),  a_last_o,  (i == 7));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check1("lsb valid after word", a_valid_o, 1'b0);
    check1("lsb ready after word", a_ready_o, 1'b1);

    // MSB-first order, two separate words
    for (int w = 0; w < 2; w++) begin
      pat = msb_words[w];
      @(posedge clk); #1 b_valid_i = 1'b1; b_data_i = pat;
      @(posedge clk); #1 b_valid_i = 1'b0; b_data_i = 8'h00;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check1($sformatf("msb w%0d data beat %0d", w, i), b_data_o, pat[7-i]);
        check1($sformatf("msb w%0d last beat %0d", w, i), b_last_o, (i == 7));
        @(posedge clk); #1;
      end
      @(negedge clk);
      check1($sformatf("msb w%0d valid after word", w), b_valid_o, 1'b0);
    end

    // Streaming: the second word is accepted on the last beat of the first
    @(posedge clk); #1 a_valid_i = 1'b1; a_data_i = 8'hFF;
    @(posedge clk); #1 a_data_i = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check1($sformatf("stream valid beat %0d", i), a_valid_o, 1'b1);
      check1($sformatf("stream data beat %0d", i),  a_data_o,  (i < 8));
      check1($sformatf("stream last beat %0d", i),  a_last_o,  (i == 7 || i == 15));
      if (i == 3) check1("stream ready mid-word", a_ready_o, 1'b0);
      if (i == 7) check1("stream ready on last",  a_ready_o, 1'b1);
      @(posedge clk); #1;
      if (i == 7) a_valid_i = 1'b0;
    end
    @(negedge clk);
    check1("stream valid after 16", a_valid_o, 1'b0);

    // Backpressure: width 4, depth 2, word 3C
    @(posedge clk); #1 c_valid_i = 1'b1; c_data_i = 8'h3C; c_ready_i = 1'b0;
    @(posedge clk); #1 c_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) c_data_i = 8'hFF;
      if (i == 5) c_ready_i = 1'b1;
      @(negedge clk);
      check ($sformatf("bp data stall %0d", i), {4'h0, c_data_o}, 8'h0C);
      check1($sformatf("bp valid stall %0d", i), c_valid_o, 1'b1);
      check1($sformatf("bp last stall %0d", i),  c_last_o,  1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check ("bp data beat 1",  {4'h0, c_data_o}, 8'h03);
    check1("bp last beat 1",  c_last_o,  1'b1);
    check1("bp ready beat 1", c_ready_o, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check1("bp valid after word", c_valid_o, 1'b0);

    // Mid-word reset, then a clean word
    @(posedge clk); #1 a_valid_i = 1'b1; a_data_i = 8'hFF;
    @(posedge clk); #1 a_valid_i = 1'b0; a_data_i = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1($sformatf("midrst pre beat %0d", i), a_data_o, 1'b1);
      @(posedge clk); #1;
    end
    check1("midrst beat 3 before reset", a_data_o, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check1("midrst async valid_o", a_valid_o, 1'b0);
    check1("midrst async data_o",  a_data_o,  1'b0);
    check1("midrst async last_o",  a_last_o,  1'b0);
    check1("midrst async ready_o", a_ready_o, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check1("midrst release ready_o", a_ready_o, 1'b1);
    check1("midrst release valid_o", a_valid_o, 1'b0);
    pat = 8'h81;
    @(posedge clk); #1 a_valid_i = 1'b1; a_data_i = pat;
    @(posedge clk); #1 a_valid_i = 1'b0; a_data_i = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check1($sformatf("post-rst data beat %0d", i), a_data_o, pat[i]);
      check1($sformatf("post-rst last beat %0d", i), a_last_o, (i == 7));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check1("post-rst valid after word", a_valid_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
